// File: rtl/hft_msg_pkg.sv
// Shared codes for the order message serializer: op codes, wire type/side
// bytes and the serializer state encoding.
package hft_msg_pkg;

  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_CANCEL = 3'd2;

  localparam logic [7:0] MSG_ADD    = 8'h41;
  localparam logic [7:0] MSG_CANCEL = 8'h58;
  localparam logic [7:0] SIDE_BUY   = 8'h42;
  localparam logic [7:0] SIDE_SELL  = 8'h53;

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    TYPE,
    BODY
  } ser_state_t;

endpackage

// File: rtl/order_msg_serializer.sv
// Serializes one add/cancel order command per handshake into a
// length-prefixed, big-endian valid/ready byte stream with sof/eof markers.
module order_msg_serializer
  import hft_msg_pkg::*;
#(
  parameter int PRICE_WIDTH = 15,
  parameter int ID_WIDTH    = 15,
  parameter int QUANT_WIDTH = 7,
  parameter int STOCK_WIDTH = 7,
  parameter int DATA_WIDTH  = 7
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic [2:0]            req_op_in,
  input  logic [STOCK_WIDTH:0]  stock_symbol_in,
  input  logic [ID_WIDTH:0]     order_id_in,
  input  logic                  order_type_in,
  input  logic [PRICE_WIDTH:0]  price_in,
  input  logic [QUANT_WIDTH:0]  quantity_in,
  output logic [DATA_WIDTH:0]   data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  sof_out,
  output logic                  eof_out,
  output logic                  err_out,
  output logic [15:0]           frame_count_out
);

  localparam int STOCK_BYTES       = (STOCK_WIDTH + 1) / 8;
  localparam int ID_BYTES          = (ID_WIDTH + 1) / 8;
  localparam int PRICE_BYTES       = (PRICE_WIDTH + 1) / 8;
  localparam int QUANT_BYTES       = (QUANT_WIDTH + 1) / 8;
  localparam int ADD_BODY_BYTES    = STOCK_BYTES + ID_BYTES + 1 + PRICE_BYTES + QUANT_BYTES;
  localparam int CANCEL_BODY_BYTES = ADD_BODY_BYTES - 1;
  localparam int ADD_LEN           = 1 + ADD_BODY_BYTES;
  localparam int CANCEL_LEN        = 1 + CANCEL_BODY_BYTES;
  localparam int BODY_W            = ADD_BODY_BYTES * 8;
  localparam int IDX_W             = $clog2(ADD_BODY_BYTES);

  localparam logic [IDX_W-1:0] ADD_LAST    = IDX_W'(ADD_BODY_BYTES - 1);
  localparam logic [IDX_W-1:0] CANCEL_LAST = IDX_W'(CANCEL_BODY_BYTES - 1);

  ser_state_t             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   is_add_q;
  logic [STOCK_WIDTH:0]   stock_q;
  logic [ID_WIDTH:0]      id_q;
  logic [7:0]             side_q;
  logic [PRICE_WIDTH:0]   price_q;
  logic [QUANT_WIDTH:0]   qty_q;
  logic [15:0]            frame_count_q;
  logic                   err_q;

  logic                   legal_op;
  logic                   accept;
  logic                   load;
  logic                   last_byte;
  logic                   eof_hs;
  logic [BODY_W-1:0]      body_vec;
  logic [7:0]             body_byte;

  assign legal_op  = (req_op_in == OP_ADD) || (req_op_in == OP_CANCEL);
  assign last_byte = (idx_q == (is_add_q ? ADD_LAST : CANCEL_LAST));
  assign eof_hs    = (state_q == BODY) && ready_in && last_byte;

  // Ready in IDLE and on the eof handshake so the next frame follows with no gap
  assign req_ready_out = (state_q == IDLE) || eof_hs;
  assign accept        = req_valid_in && req_ready_out;
  assign load          = accept && legal_op;

  assign err_out         = err_q;
  assign frame_count_out = frame_count_q;

  // Cancel layout is left-aligned and padded so both layouts share one byte index
  assign body_vec = is_add_q ? {stock_q, id_q, side_q, price_q, qty_q}
                             : {stock_q, id_q, price_q, qty_q, 8'h00};

  // Pick the body byte addressed by the index, MSB byte first
  always_comb begin
    body_byte = '0;
    for (int unsigned i = 0; i < ADD_BODY_BYTES; i++) begin
      if (idx_q == IDX_W'(i)) body_byte = body_vec[BODY_W - 8 - 8*i +: 8];
    end
  end

  // Next-state and stream outputs from the current state
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    valid_out = 1'b0;
    sof_out   = 1'b0;
    eof_out   = 1'b0;
    data_out  = '0;
    unique case (state_q)
      IDLE: begin
        if (load) state_d = LEN;
      end
      LEN: begin
        valid_out = 1'b1;
        sof_out   = 1'b1;
        data_out  = is_add_q ? 8'(ADD_LEN) : 8'(CANCEL_LEN);
        if (ready_in) state_d = TYPE;
      end
      TYPE: begin
        valid_out = 1'b1;
        data_out  = is_add_q ? MSG_ADD : MSG_CANCEL;
        if (ready_in) begin
          state_d = BODY;
          idx_d   = '0;
        end
      end
      BODY: begin
        valid_out = 1'b1;
        data_out  = body_byte;
        eof_out   = last_byte;
        if (ready_in) begin
          if (last_byte) state_d = load ? LEN : IDLE;
          else           idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and byte index registers
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Capture the command fields on a legal accept only
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      is_add_q <= 1'b0;
      stock_q  <= '0;
      id_q     <= '0;
      side_q   <= '0;
      price_q  <= '0;
      qty_q    <= '0;
    end else if (load) begin
      is_add_q <= (req_op_in == OP_ADD);
      stock_q  <= stock_symbol_in;
      id_q     <= order_id_in;
      side_q   <= order_type_in ? SIDE_BUY : SIDE_SELL;
      price_q  <= price_in;
      qty_q    <= quantity_in;
    end
  end

  // Completed-frame counter and one-cycle illegal-op pulse
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      frame_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      if (eof_hs) frame_count_q <= frame_count_q + 16'd1;
      err_q <= accept && !legal_op;
    end
  end

endmodule

// File: tb/tb_order_msg_serializer.sv
// Directed bench for order_msg_serializer: frame contents, stalls,
// back-to-back frames, illegal ops and mid-frame reset.
module tb_order_msg_serializer;

  logic        clk_in = 1'b0;
  logic        reset_n_in = 1'b1;
  logic        req_valid_in = 1'b0;
  logic        req_ready_out;
  logic [2:0]  req_op_in = '0;
  logic [7:0]  stock_symbol_in = '0;
  logic [15:0] order_id_in = '0;
  logic        order_type_in = 1'b0;
  logic [15:0] price_in = '0;
  logic [7:0]  quantity_in = '0;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic        sof_out;
  logic        eof_out;
  logic        err_out;
  logic [15:0] frame_count_out;

  int total = 0;
  int bad = 0;

  order_msg_serializer #(
    .PRICE_WIDTH(15),
    .ID_WIDTH(15),
    .QUANT_WIDTH(7),
    .STOCK_WIDTH(7),
    .DATA_WIDTH(7)
  ) dut (
    .clk_in(clk_in),
    .reset_n_in(reset_n_in),
    .req_valid_in(req_valid_in),
    .req_ready_out(req_ready_out),
    .req_op_in(req_op_in),
    .stock_symbol_in(stock_symbol_in),
    .order_id_in(order_id_in),
    .order_type_in(order_type_in),
    .price_in(price_in),
    .quantity_in(quantity_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .sof_out(sof_out),
    .eof_out(eof_out),
    .err_out(err_out),
    .frame_count_out(frame_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic set_cmd(input logic [2:0] op, input logic [7:0] s, input logic [15:0] id,
                         input logic side, input logic [15:0] p, input logic [7:0] q);
    req_op_in       = op;
    stock_symbol_in = s;
    order_id_in     = id;
    order_type_in   = side;
    price_in        = p;
    quantity_in     = q;
    req_valid_in    = 1'b1;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    #2 reset_n_in = 1'b0;
    #3;
    total++;
    if (valid_out !== 1'b0 || sof_out !== 1'b0 || eof_out !== 1'b0 || err_out !== 1'b0 ||
        data_out !== 8'h00 || frame_count_out !== 16'd0 || req_ready_out !== 1'b1) begin
      bad++;
      $display("FAIL reset: valid=%b sof=%b eof=%b err=%b data=%h fc=%0d rdy=%b, expected 0 0 0 0 00 0 1",
               valid_out, sof_out, eof_out, err_out, data_out, frame_count_out, req_ready_out);
    end
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    step();
  endtask

  task automatic test_add();
    logic [7:0] e [9];
    e = '{8'h08, 8'h41, 8'h2A, 8'h12, 8'h34, 8'h42, 8'h00, 8'hC8, 8'h05};
    ready_in = 1'b1;
    set_cmd(3'd1, 8'h2A, 16'h1234, 1'b1, 16'h00C8, 8'h05);
    total++;
    if (req_ready_out !== 1'b1) begin
      bad++;
      $display("FAIL add_ready: rdy=%b expected 1", req_ready_out);
    end
    step();
    req_valid_in = 1'b0;
    // Modify inputs after accept; the frame must not change
    set_cmd(3'd2, 8'hFF, 16'hFFFF, 1'b0, 16'hFFFF, 8'hFF);
    req_valid_in = 1'b0;
    for (int k = 0; k < 9; k++) begin
      total++;
      if (valid_out !== 1'b1 || data_out !== e[k] || sof_out !== (k == 0) || eof_out !== (k == 8)) begin
        bad++;
        $display("FAIL add byte%0d: data=%h valid=%b sof=%b eof=%b, expected data=%h valid=1 sof=%b eof=%b",
                 k, data_out, valid_out, sof_out, eof_out, e[k], k == 0, k == 8);
      end
      if (k == 8) begin
        total++;
        if (frame_count_out !== 16'd0) begin
          bad++;
          $display("FAIL add_fc_before: fc=%0d expected 0", frame_count_out);
        end
      end
      step();
    end
    total++;
    if (valid_out !== 1'b0 || frame_count_out !== 16'd1) begin
      bad++;
      $display("FAIL add_end: valid=%b fc=%0d expected valid=0 fc=1", valid_out, frame_count_out);
    end
  endtask

  task automatic test_cancel();
    logic [7:0] e [8];
    e = '{8'h07, 8'h58, 8'h07, 8'hBE, 8'hEF, 8'h01, 8'h00, 8'h10};
    set_cmd(3'd2, 8'h07, 16'hBEEF, 1'b1, 16'h0100, 8'h10);
    step();
    req_valid_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (valid_out !== 1'b1 || data_out !== e[k] || sof_out !== (k == 0) || eof_out !== (k == 7)) begin
        bad++;
        $display("FAIL cancel byte%0d: data=%h valid=%b sof=%b eof=%b, expected data=%h valid=1 sof=%b eof=%b",
                 k, data_out, valid_out, sof_out, eof_out, e[k], k == 0, k == 7);
      end
      step();
    end
    total++;
    if (valid_out !== 1'b0 || frame_count_out !== 16'd2) begin
      bad++;
      $display("FAIL cancel_end: valid=%b fc=%0d expected valid=0 fc=2", valid_out, frame_count_out);
    end
  endtask

  task automatic test_stall();
    logic [7:0] e [9];
    e = '{8'h08, 8'h41, 8'h2A, 8'h12, 8'h34, 8'h42, 8'h00, 8'hC8, 8'h05};
    set_cmd(3'd1, 8'h2A, 16'h1234, 1'b1, 16'h00C8, 8'h05);
    step();
    req_valid_in = 1'b0;
    for (int k = 0; k < 9; k++) begin
      total++;
      if (valid_out !== 1'b1 || data_out !== e[k] || sof_out !== (k == 0) || eof_out !== (k == 8)) begin
        bad++;
        $display("FAIL stall byte%0d: data=%h valid=%b sof=%b eof=%b, expected data=%h valid=1 sof=%b eof=%b",
                 k, data_out, valid_out, sof_out, eof_out, e[k], k == 0, k == 8);
      end
      if (k == 4) begin
        ready_in = 1'b0;
        for (int h = 0; h < 3; h++) begin
          step();
          total++;
          if (valid_out !== 1'b1 || data_out !== 8'h34 || sof_out !== 1'b0 || eof_out !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold%0d: data=%h valid=%b sof=%b eof=%b, expected data=34 valid=1 sof=0 eof=0",
                     h, data_out, valid_out, sof_out, eof_out);
          end
        end
        ready_in = 1'b1;
      end
      step();
    end
    total++;
    if (valid_out !== 1'b0 || frame_count_out !== 16'd3) begin
      bad++;
      $display("FAIL stall_end: valid=%b fc=%0d expected valid=0 fc=3", valid_out, frame_count_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e [18];
    e = '{8'h08, 8'h41, 8'h2A, 8'h12, 8'h34, 8'h42, 8'h00, 8'hC8, 8'h05,
          8'h08, 8'h41, 8'h11, 8'hA5, 8'hA5, 8'h53, 8'h7F, 8'hFF, 8'hFF};
    set_cmd(3'd1, 8'h2A, 16'h1234, 1'b1, 16'h00C8, 8'h05);
    step();
    set_cmd(3'd1, 8'h11, 16'hA5A5, 1'b0, 16'h7FFF, 8'hFF);
    for (int k = 0; k < 18; k++) begin
      total++;
      if (valid_out !== 1'b1 || data_out !== e[k] || sof_out !== (k == 0 || k == 9) ||
          eof_out !== (k == 8 || k == 17)) begin
        bad++;
        $display("FAIL b2b byte%0d: data=%h valid=%b sof=%b eof=%b, expected data=%h valid=1 sof=%b eof=%b",
                 k, data_out, valid_out, sof_out, eof_out, e[k], k == 0 || k == 9, k == 8 || k == 17);
      end
      if (k == 3 || k == 8) begin
        total++;
        if (req_ready_out !== (k == 8)) begin
          bad++;
          $display("FAIL b2b_ready%0d: rdy=%b expected %b", k, req_ready_out, k == 8);
        end
      end
      if (k == 9) begin
        req_valid_in = 1'b0;
        total++;
        if (frame_count_out !== 16'd4) begin
          bad++;
          $display("FAIL b2b_fc_mid: fc=%0d expected 4", frame_count_out);
        end
      end
      step();
    end
    total++;
    if (valid_out !== 1'b0 || frame_count_out !== 16'd5) begin
      bad++;
      $display("FAIL b2b_end: valid=%b fc=%0d expected valid=0 fc=5", valid_out, frame_count_out);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] e [8];
    e = '{8'h07, 8'h58, 8'hF0, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00};
    set_cmd(3'd3, 8'h2A, 16'h1234, 1'b1, 16'h00C8, 8'h05);
    total++;
    if (req_ready_out !== 1'b1 || err_out !== 1'b0) begin
      bad++;
      $display("FAIL illegal_pre: rdy=%b err=%b expected rdy=1 err=0", req_ready_out, err_out);
    end
    step();
    req_valid_in = 1'b0;
    total++;
    if (err_out !== 1'b1 || valid_out !== 1'b0) begin
      bad++;
      $display("FAIL illegal_pulse: err=%b valid=%b expected err=1 valid=0", err_out, valid_out);
    end
    step();
    total++;
    if (err_out !== 1'b0 || valid_out !== 1'b0 || req_ready_out !== 1'b1 || frame_count_out !== 16'd5) begin
      bad++;
      $display("FAIL illegal_after: err=%b valid=%b rdy=%b fc=%0d expected err=0 valid=0 rdy=1 fc=5",
               err_out, valid_out, req_ready_out, frame_count_out);
    end
    set_cmd(3'd2, 8'hF0, 16'h0001, 1'b0, 16'hFFFF, 8'h00);
    step();
    req_valid_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (valid_out !== 1'b1 || data_out !== e[k] || sof_out !== (k == 0) || eof_out !== (k == 7) ||
          err_out !== 1'b0) begin
        bad++;
        $display("FAIL illegal_cancel byte%0d: data=%h valid=%b sof=%b eof=%b err=%b, expected data=%h valid=1 sof=%b eof=%b err=0",
                 k, data_out, valid_out, sof_out, eof_out, err_out, e[k], k == 0, k == 7);
      end
      step();
    end
    total++;
    if (frame_count_out !== 16'd6) begin
      bad++;
      $display("FAIL illegal_fc: fc=%0d expected 6", frame_count_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] e [9];
    e = '{8'h08, 8'h41, 8'h2A, 8'h12, 8'h34, 8'h42, 8'h00, 8'hC8, 8'h05};
    set_cmd(3'd1, 8'h2A, 16'h1234, 1'b1, 16'h00C8, 8'h05);
    step();
    req_valid_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (valid_out !== 1'b1 || data_out !== e[k]) begin
        bad++;
        $display("FAIL rst_pre byte%0d: data=%h valid=%b expected data=%h valid=1", k, data_out, valid_out, e[k]);
      end
      if (k < 5) step();
    end
    #2 reset_n_in = 1'b0;
    #1;
    total++;
    if (valid_out !== 1'b0 || sof_out !== 1'b0 || eof_out !== 1'b0 || data_out !== 8'h00 ||
        frame_count_out !== 16'd0) begin
      bad++;
      $display("FAIL rst_async: valid=%b sof=%b eof=%b data=%h fc=%0d expected 0 0 0 00 0",
               valid_out, sof_out, eof_out, data_out, frame_count_out);
    end
    @(negedge clk_in);
    reset_n_in = 1'b1;
    step();
    set_cmd(3'd1, 8'h2A, 16'h1234, 1'b1, 16'h00C8, 8'h05);
    step();
    req_valid_in = 1'b0;
    for (int k = 0; k < 9; k++) begin
      total++;
      if (valid_out !== 1'b1 || data_out !== e[k] || sof_out !== (k == 0) || eof_out !== (k == 8)) begin
        bad++;
        $display("FAIL rst_post byte%0d: data=%h valid=%b sof=%b eof=%b, expected data=%h valid=1 sof=%b eof=%b",
                 k, data_out, valid_out, sof_out, eof_out, e[k], k == 0, k == 8);
      end
      step();
    end
    total++;
    if (valid_out !== 1'b0 || frame_count_out !== 16'd1) begin
      bad++;
      $display("FAIL rst_post_end: valid=%b fc=%0d expected valid=0 fc=1", valid_out, frame_count_out);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cancel();
    test_stall();
    test_back_to_back();
    test_illegal();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/order_msg_serializer.md
Name: order_msg_serializer

Overview:
Transmit-side counterpart of the market byte-stream parser. It accepts one order command per handshake (add or cancel, with the same field set the parser produces) and serializes it into the length-prefixed, big-endian byte stream format that the parser consumes. It sits between the strategy/order-book logic and the network egress MAC. Output is a valid/ready byte stream with start-of-frame and end-of-frame markers.

Parameters:
PRICE_WIDTH, 15, MSB index of price field (16 bits); (PRICE_WIDTH+1) must be a multiple of 8
ID_WIDTH, 15, MSB index of order ID (16 bits); multiple-of-8 rule
QUANT_WIDTH, 7, MSB index of quantity (8 bits); multiple-of-8 rule
STOCK_WIDTH, 7, MSB index of stock symbol (8 bits); multiple-of-8 rule
DATA_WIDTH, 7, MSB index of output byte; fixed at 7

Ports:
clk_in  input  1  clock; all logic on rising edge
reset_n_in  input  1  asynchronous active-low reset
req_valid_in  input  1  command valid
req_ready_out  output  1  command accepted when high with req_valid_in
req_op_in  input  3  3'd1 add, 3'd2 cancel, other values illegal
stock_symbol_in  input  STOCK_WIDTH+1  stock symbol
order_id_in  input  ID_WIDTH+1  order ID
order_type_in  input  1  add only: 1 buy, 0 sell
price_in  input  PRICE_WIDTH+1  price
quantity_in  input  QUANT_WIDTH+1  quantity
data_out  output  DATA_WIDTH+1  stream byte
valid_out  output  1  data_out valid
ready_in  input  1  downstream accepts byte when high with valid_out
sof_out  output  1  high with the length byte
eof_out  output  1  high with the final byte
err_out  output  1  one-cycle pulse on illegal op
frame_count_out  output  16  completed frames, wraps at 0xFFFF -> 0

Behaviour:
- Frame format: [LEN][TYPE][body], with multi-byte fields MSB-byte first. LEN is the number of bytes after LEN.
- Add frame: LEN, 0x41 'A', stock, order_id, side (0x42 'B' for buy, 0x53 'S' for sell), price, quantity. With defaults LEN = 8 and the total frame is 9 bytes.
- Cancel frame: LEN, 0x58 'X', stock, order_id, price, quantity. With defaults LEN = 7 and the total frame is 8 bytes.
- LEN values are derived from the parameter byte counts as localparams.
- Reset (reset_n_in low, asynchronous):
  - state = IDLE.
  - valid_out, sof_out, eof_out, err_out, data_out = 0.
  - frame_count_out = 0.
  - Captured fields and byte index = 0.
- FSM states:
  - IDLE: req_ready_out = 1. A legal accept captures all fields and op into registers and goes to LEN.
  - LEN: valid_out = 1, data_out = LEN, sof_out = 1. Advances to TYPE on ready_in.
  - TYPE: emits the type byte. Advances to BODY on ready_in.
  - BODY: byte index counts 0..N-1 through the body bytes. On the last byte eof_out = 1. When that byte is accepted, frame_count_out increments.
- Latency: a command accepted on cycle N produces the LEN byte valid at cycle N+1. With ready_in held high, one byte is emitted per cycle.
- Stream rule: while valid_out=1 and ready_in=0, data_out, sof_out and eof_out hold stable. valid_out never drops mid-frame.
- Back-to-back frames: req_ready_out is also high on the cycle the eof byte is handshaken (valid_out & eof_out & ready_in). A command accepted then puts the new LEN byte on the next cycle, giving zero gap. Otherwise the block returns to IDLE.
- Illegal op: the command is accepted (req_ready_out high), no bytes are emitted, err_out pulses for one cycle, and the state stays IDLE.
- Inputs are sampled only at accept. Changes afterwards do not affect the frame in flight.
- Reset mid-frame: the frame is truncated immediately with no eof. Downstream resyncs on the next sof.
- Fields are zero-extended as given. No range checking beyond op.

Decomposition:
- Package hft_msg_pkg holds:
  - op codes (OP_ADD = 3'd1, OP_CANCEL = 3'd2)
  - type bytes (MSG_ADD = 8'h41, MSG_CANCEL = 8'h58)
  - side bytes (SIDE_BUY = 8'h42, SIDE_SELL = 8'h53)
  - the ser_state_t enum (IDLE, LEN, TYPE, BODY)
- Byte counts remain module localparams because they depend on the parameters.
- No sub-module. Body byte selection is a single case on byte index over the captured-field concatenation (add and cancel layouts).

Test Plan:
- Add with stock 0x2A, id 0x1234, buy, price 0x00C8, qty 0x05, ready_in=1 -> bytes 08 41 2A 12 34 42 00 C8 05 on consecutive cycles, sof on 08, eof on 05, frame_count_out 0 -> 1.
- Cancel with stock 0x07, id 0xBEEF, price 0x0100, qty 0x10 -> bytes 07 58 07 BE EF 01 00 10, no side byte.
- Add as in the first scenario with ready_in low for 3 cycles while byte 0x34 is presented -> data_out holds 0x34 and valid_out holds 1, then 42 00 C8 05 follow, and the frame is intact.
- Two adds presented back-to-back with req_valid_in held -> the second LEN byte appears on the cycle after the first eof handshake, with no idle cycle and frame_count_out = 2.
- req_op_in = 3'd3 -> accepted, err_out pulses for exactly one cycle, valid_out stays 0, and a following legal cancel serializes normally.
- reset_n_in asserted during the BODY byte of an add -> valid_out = 0 immediately (asynchronously), frame_count_out = 0, and after release a new add produces a full 9-byte frame starting with sof.
